// File: rtl/fifo_reader_pkg.sv
// fifo_reader_pkg: shared types for the fifo_reader consumer-side controller.
//   state_e       - controller state (IDLE / RUN / FLUSH)
//   SKID_DEPTH    - number of entries in the re-timing buffer
//   skid_entry_w  - packed width of one buffer entry {data, last}
package fifo_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam int unsigned SKID_DEPTH = 2;

  // Width of a buffer entry: data word plus the end-of-frame marker.
  function automatic int unsigned skid_entry_w(input int unsigned width);
    return width + 1;
  endfunction

endpackage

// File: rtl/fifo_reader_skid.sv
// fifo_reader_skid: 2-entry re-timing buffer between the FIFO pop port and
// the registered downstream stream.
//   clk, rst_n               - clock, synchronous active-low reset
//   clear_i                  - drop all entries (has priority over push/pop)
//   push_i, push_data_i,
//   push_last_i              - write {data, last} at the tail
//   pop_i                    - advance the head (ignored when empty)
//   head_data_o, head_last_o - head entry
//   count_o                  - number of valid entries, 0..2
module fifo_reader_skid
  import fifo_reader_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             push_last_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_data_o,
  output logic             head_last_o,
  output logic [1:0]       count_o
);

  // Package types cannot see WIDTH, so the entry layout is declared here.
  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
  } entry_t;

  entry_t     mem_q [SKID_DEPTH];
  logic       rd_ptr_q;
  logic       wr_ptr_q;
  logic [1:0] cnt_q;

  logic do_pop;
  logic do_push;

  assign do_pop  = pop_i && (cnt_q != 2'd0);
  // A full buffer only accepts a word when the head leaves in the same cycle.
  assign do_push = push_i && ((cnt_q != 2'd2) || do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SKID_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else if (clear_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= '{data: push_data_i, last: push_last_i};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head_data_o = mem_q[rd_ptr_q].data;
  assign head_last_o = mem_q[rd_ptr_q].last;
  assign count_o     = cnt_q;

endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: consumer-side controller for a zero-latency regular FIFO.
// Pops words, re-times them through a 2-entry buffer onto a valid/ready
// stream, marks the last word of every FRAME_LEN-word frame, and supports a
// flush that discards the buffer and drains the FIFO.
//   clk, rst_n              - clock, synchronous active-low reset
//   enable                  - level, permits popping (checked at frame edges)
//   flush                   - one-cycle request to discard and drain
//   fifo_empty, fifo_valid,
//   fifo_rdata, fifo_pop    - FIFO read port (data/valid same cycle as pop)
//   out_valid, out_ready,
//   out_data, out_last      - downstream stream
//   busy                    - controller is not idle
//   flush_done              - one-cycle pulse when a flush completes
//   check_err               - sticky protocol error (only with
//                             FIFO_READER_CHECK_EN defined)
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned FRAME_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             flush,
  input  logic             fifo_empty,
  input  logic             fifo_valid,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             fifo_pop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             flush_done
`ifdef FIFO_READER_CHECK_EN
  ,
  output logic             check_err
`endif
);

  localparam int unsigned FC_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAME_LEN - 1);

  state_e          state_q;
  logic [FC_W-1:0] frame_cnt_q;
  logic            flush_done_q;

  logic [1:0] buf_cnt;
  logic       frame_end;
  logic       run_pop;
  logic       capture;
  logic       handoff;
  logic       buf_clear;

  assign frame_end = (frame_cnt_q == FC_LAST);

  // With enable low at a frame boundary the controller is about to leave RUN,
  // so it must not start a new frame in that same cycle.
  assign run_pop = !fifo_empty && (buf_cnt != 2'd2) && !flush &&
                   (enable || (frame_cnt_q != '0));

  always_comb begin
    fifo_pop = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        ST_RUN:   fifo_pop = run_pop;
        ST_FLUSH: fifo_pop = !fifo_empty;
        default:  fifo_pop = 1'b0;
      endcase
    end
  end

  assign capture   = fifo_pop && fifo_valid && (state_q == ST_RUN);
  assign out_valid = (buf_cnt != 2'd0);
  assign handoff   = out_valid && out_ready;
  // Clearing wins over a simultaneous handoff, so that word is never delivered.
  assign buf_clear = flush && (state_q != ST_FLUSH);

  fifo_reader_skid #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (buf_clear),
    .push_i      (capture),
    .push_data_i (fifo_rdata),
    .push_last_i (frame_end),
    .pop_i       (handoff),
    .head_data_o (out_data),
    .head_last_o (out_last),
    .count_o     (buf_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      frame_cnt_q  <= '0;
      flush_done_q <= 1'b0;
    end else begin
      flush_done_q <= 1'b0;
      if (capture) begin
        frame_cnt_q <= frame_end ? '0 : frame_cnt_q + FC_W'(1);
      end
      unique case (state_q)
        ST_IDLE: begin
          if (flush) begin
            state_q     <= ST_FLUSH;
            frame_cnt_q <= '0;
          end else if (enable) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (flush) begin
            state_q     <= ST_FLUSH;
            frame_cnt_q <= '0;
          end else if (!enable &&
                       ((frame_cnt_q == '0) || (capture && frame_end))) begin
            state_q <= ST_IDLE;
          end
        end
        ST_FLUSH: begin
          if (fifo_empty) begin
            state_q      <= ST_IDLE;
            flush_done_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign flush_done = flush_done_q;

`ifdef FIFO_READER_CHECK_EN
  logic check_err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      check_err_q <= 1'b0;
    end else if ((fifo_valid != fifo_pop) ||
                 (capture && (buf_cnt == 2'd2) && !handoff)) begin
      check_err_q <= 1'b1;
    end
  end

  assign check_err = check_err_q;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: directed self-checking bench for fifo_reader with a
// behavioural zero-latency FIFO on the read side.
module tb_fifo_reader;

  localparam int unsigned W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, enable, flush, out_ready, bad_valid;
  logic         fifo_empty, fifo_valid, fifo_pop;
  logic         out_valid, out_last, busy, flush_done;
  logic [W-1:0] fifo_rdata, out_data;
`ifdef FIFO_READER_CHECK_EN
  logic         check_err;
`endif

  fifo_reader #(
    .WIDTH     (W),
    .FRAME_LEN (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .flush      (flush),
    .fifo_empty (fifo_empty),
    .fifo_valid (fifo_valid),
    .fifo_rdata (fifo_rdata),
    .fifo_pop   (fifo_pop),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .flush_done (flush_done)
`ifdef FIFO_READER_CHECK_EN
    ,
    .check_err  (check_err)
`endif
  );

  // Zero-latency FIFO model: head word visible combinationally, pop advances.
  logic [W-1:0] fmem [0:127];
  int f_wr = 0;
  int f_rd = 0;

  assign fifo_empty = (f_rd == f_wr);
  assign fifo_rdata = fmem[f_rd[6:0]];
  assign fifo_valid = fifo_pop && !bad_valid;

  always @(posedge clk) begin
    if (fifo_pop) f_rd <= f_rd + 1;
  end

  // Monitor: delivered words, pop statistics, flush_done pulses.
  logic [W:0] log_q [$];
  int popcnt = 0, run_len = 0, max_run = 0, empty_pop = 0, fdcnt = 0;

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !flush) log_q.push_back({out_last, out_data});
    if (fifo_pop) begin
      popcnt++;
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
    if (fifo_pop && fifo_empty) empty_pop++;
    if (flush_done) fdcnt++;
  end

  int total = 0, passed = 0, fails = 0;
  int pb, lb, fb;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [W-1:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      fmem[f_wr[6:0]] = first + W'(i);
      f_wr++;
    end
  endtask

  function automatic logic [31:0] ent(input int idx);
    if (idx < log_q.size()) return {15'd0, log_q[idx]};
    return 32'hDEAD_DEAD;
  endfunction

  // n words first, first+1, ... as one aligned frame sequence (last every 4th).
  task automatic chk_words(input string tag, input int lbase, input logic [W-1:0] first,
                           input int n);
    logic [31:0] exp;
    chk({tag, "_count"}, log_q.size() - lbase, n);
    for (int i = 0; i < n; i++) begin
      exp = {16'd0, first + W'(i)};
      if (i % 4 == 3) exp[16] = 1'b1;
      chk($sformatf("%s_w%0d", tag, i), ent(lbase + i), exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; flush = 1'b0; out_ready = 1'b1; bad_valid = 1'b0;
    repeat (3) tick();
    look();
    chk("rst_pop", fifo_pop, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fdone", flush_done, 0);
`ifdef FIFO_READER_CHECK_EN
    chk("rst_cerr", check_err, 0);
`endif

    // Streaming: 8 words, full throughput.
    tick(); rst_n = 1'b1; enable = 1'b1; load(16'h0001, 8);
    pb = popcnt; lb = log_q.size();
    look(); chk("t1_idle_nopop", fifo_pop, 0);
    tick(); look();
    chk("t1_first_pop", fifo_pop, 1);
    chk("t1_no_valid_yet", out_valid, 0);
    chk("t1_busy", busy, 1);
    tick(); look();
    chk("t1_latency_valid", out_valid, 1);
    chk("t1_latency_data", out_data, 16'h0001);
    repeat (10) tick();
    look();
    chk("t1_pops", popcnt - pb, 8);
    chk("t1_pop_run", max_run, 8);
    chk_words("t1", lb, 16'h0001, 8);

    // Backpressure: out_ready low for 5 cycles mid-stream.
    tick(); load(16'h0009, 8);
    pb = popcnt; lb = log_q.size();
    tick(); tick(); tick(); out_ready = 1'b0;
    look(); chk("t2_stall_head", out_data, 16'h000b);
    repeat (4) tick();
    look();
    chk("t2_full_nopop", fifo_pop, 0);
    chk("t2_hold_valid", out_valid, 1);
    chk("t2_hold_data", out_data, 16'h000b);
    chk("t2_hold_last", out_last, 0);
    tick(); out_ready = 1'b1;
    repeat (12) tick();
    look();
    chk("t2_pops", popcnt - pb, 8);
    chk_words("t2", lb, 16'h0009, 8);

    // enable dropped after the 2nd word of a frame.
    tick(); load(16'h0021, 8);
    pb = popcnt; lb = log_q.size();
    tick(); tick(); enable = 1'b0;
    repeat (8) tick();
    look();
    chk("t3_busy", busy, 0);
    chk("t3_nopop", fifo_pop, 0);
    chk("t3_pops", popcnt - pb, 4);
    chk_words("t3", lb, 16'h0021, 4);

    // Flush with 2 words buffered and 5 in the FIFO.
    tick(); out_ready = 1'b0; enable = 1'b1;
    tick(); tick(); tick(); load(16'h0029, 3);
    look();
    chk("t4_full_nopop", fifo_pop, 0);
    chk("t4_buffered_head", out_data, 16'h0025);
    tick(); flush = 1'b1; out_ready = 1'b1; enable = 1'b0;
    pb = popcnt; lb = log_q.size(); fb = fdcnt;
    look(); chk("t4_flush_cycle_nopop", fifo_pop, 0);
    tick(); flush = 1'b0;
    look();
    chk("t4_valid_dropped", out_valid, 0);
    chk("t4_busy", busy, 1);
    chk("t4_drain_pop", fifo_pop, 1);
    repeat (5) tick();
    look();
    chk("t4_drained_nopop", fifo_pop, 0);
    chk("t4_fdone_not_yet", flush_done, 0);
    tick(); look();
    chk("t4_fdone", flush_done, 1);
    chk("t4_idle", busy, 0);
    tick(); look();
    chk("t4_fdone_pulse", flush_done, 0);
    chk("t4_fdone_count", fdcnt - fb, 1);
    chk("t4_pops", popcnt - pb, 5);
    chk("t4_fifo_empty", f_wr - f_rd, 0);
    chk("t4_nothing_delivered", log_q.size() - lb, 0);
    tick(); enable = 1'b1; load(16'h0031, 4);
    lb = log_q.size();
    repeat (8) tick();
    look();
    chk_words("t4_next", lb, 16'h0031, 4);

    // Flush with the FIFO already empty.
    tick(); enable = 1'b0;
    tick(); look(); chk("t4e_idle", busy, 0);
    tick(); flush = 1'b1; fb = fdcnt;
    tick(); flush = 1'b0;
    look();
    chk("t4e_busy", busy, 1);
    chk("t4e_nopop", fifo_pop, 0);
    chk("t4e_fdone_not_yet", flush_done, 0);
    tick(); look();
    chk("t4e_fdone", flush_done, 1);
    chk("t4e_idle_after", busy, 0);
    tick(); look();
    chk("t4e_fdone_count", fdcnt - fb, 1);

    // Reset for one cycle mid-frame with 3 words of the frame remaining.
    tick(); enable = 1'b1; load(16'h0041, 4);
    tick();
    tick(); rst_n = 1'b0;
    look(); chk("t5_pop_in_reset", fifo_pop, 0);
    tick(); rst_n = 1'b1; load(16'h0045, 1);
    lb = log_q.size();
    look();
    chk("t5_valid", out_valid, 0);
    chk("t5_data", out_data, 0);
    chk("t5_last", out_last, 0);
    chk("t5_busy", busy, 0);
    chk("t5_fdone", flush_done, 0);
    chk("t5_pop", fifo_pop, 0);
    repeat (9) tick();
    look();
    chk_words("t5", lb, 16'h0042, 4);

`ifdef FIFO_READER_CHECK_EN
    chk("ce_clean", check_err, 0);
    tick(); load(16'h0051, 2); bad_valid = 1'b1;
    tick(); bad_valid = 1'b0;
    look(); chk("ce_set", check_err, 1);
    repeat (4) tick();
    look(); chk("ce_sticky", check_err, 1);
    tick(); rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    look(); chk("ce_cleared", check_err, 0);
`endif

    chk("never_pop_empty", empty_pop, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
